// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative shift-add multiplier / restoring divider with HI/LO
//            registers for the EX stage. One iteration per operand bit.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int               c_cw       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0]  c_cnt_last = c_cw'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic [c_cw-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_opb;

    logic               w_idle;
    logic               w_mdu_req;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_idle    = (r_state == S_IDLE);
    assign w_mdu_req = start & w_idle & ~MDOp[2];
    assign w_mthi    = start & w_idle & (MDOp == 3'b100);
    assign w_mtlo    = start & w_idle & (MDOp == 3'b101);

    // Signed ops (even MDOp) run on magnitudes; signs are reapplied in FIX.
    assign w_neg_a = ~MDOp[0] & A[WIDTH-1];
    assign w_neg_b = ~MDOp[0] & B[WIDTH-1];
    assign w_a_mag = w_neg_a ? -A : A;
    assign w_b_mag = w_neg_b ? -B : B;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_opb};
    assign w_addend = r_mq[0] ? w_sum : {1'b0, r_acc};

    // Partial remainder stays below the divisor, so bit WIDTH of the
    // difference is exactly the borrow of the trial subtraction.
    assign w_sh   = {r_acc, r_mq[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_opb};
    assign w_ge   = ~w_diff[WIDTH];

    assign w_prod     = {r_acc, r_mq};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_mq : r_mq);
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_mdu_req) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_cnt_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_opb    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mdu_req) begin
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= MDOp[1];
                        r_neg_q  <= w_neg_a ^ w_neg_b;
                        r_neg_r  <= w_neg_a;
                        r_dz     <= MDOp[1] & (B == '0);
                        r_acc    <= '0;
                        r_mq     <= w_a_mag;
                        r_opb    <= w_b_mag;
                    end else if (w_mthi) begin
                        r_hi <= A;
                    end else if (w_mtlo) begin
                        r_lo <= A;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + c_cw'(1);
                    if (r_is_div) begin
                        r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_addend[WIDTH:1];
                        r_mq  <= {w_addend[0], r_mq[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
